fetch_sequencer: RTL

- Instruction-issue end of the CPU: owns the program counter and reads the synchronous instruction ROM.
- Resolves BRN/BRN_Z/BRN_N/BRN_O internally and hands every other instruction word to the execute stage over a valid/ready handshake.
- Its issued stream is the ROM_data stream that execute and the reference model consume.

---
 rtl/fetch_sequencer_pkg.sv | 39 +++
 rtl/fetch_sequencer_branch_resolve.sv | 64 ++++++
 rtl/fetch_sequencer.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer_pkg
// Purpose  : Shared CPU definitions used by the fetch/issue end of the core.
//            Holds the opcode encoding, the field widths and the fetch FSM
//            state type.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_sequencer_pkg;

    localparam int c_OP_W = 4;

    // Opcode encoding. Codes 9..11 are unassigned; words carrying them are
    // still issued so that execute can raise the illegal-instruction error.
    typedef enum logic [c_OP_W-1:0] {
        OP_ADD     = 4'd0,
        OP_SUB     = 4'd1,
        OP_AND     = 4'd2,
        OP_OR      = 4'd3,
        OP_XOR     = 4'd4,
        OP_NOT     = 4'd5,
        OP_MOV     = 4'd6,
        OP_LOAD_IM = 4'd7,
        OP_NOP     = 4'd8,
        OP_BRN_Z   = 4'd12,
        OP_BRN_N   = 4'd13,
        OP_BRN_O   = 4'd14,
        OP_BRN     = 4'd15
    } opcode_t;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        RUN        = 2'd1,
        WAIT_FLAGS = 2'd2,
        HALT       = 2'd3
    } fetch_state_t;

endpackage : fetch_sequencer_pkg
`default_nettype wire

// File: rtl/fetch_sequencer_branch_resolve.sv
`default_nettype none
// ============================================================================
// Module   : branch_resolve
// Purpose  : Combinational branch decode. Classifies the opcode of the word
//            on the ROM output and evaluates the branch condition.
// Ports    : op        - opcode field of the fetched word
//            operand   - {ra,rb} field, used as an absolute branch target
//            flag_z/n/o- execute-stage status flags
//            is_branch - word is one of BRN, BRN_Z, BRN_N, BRN_O
//            is_cond   - word is a conditional branch
//            taken     - branch would redirect given the current flags
//            target    - absolute redirect address
// Revision : 1.0 - initial release
// ============================================================================
module branch_resolve
    import fetch_sequencer_pkg::*;
#(
    parameter int TARGET_W = 6
) (
    input  logic [c_OP_W-1:0]   op,
    input  logic [TARGET_W-1:0] operand,
    input  logic                flag_z,
    input  logic                flag_n,
    input  logic                flag_o,
    output logic                is_branch,
    output logic                is_cond,
    output logic                taken,
    output logic [TARGET_W-1:0] target
);

    opcode_t w_op;
    assign w_op   = opcode_t'(op);
    assign target = operand;

    always_comb begin
        is_branch = 1'b0;
        is_cond   = 1'b0;
        taken     = 1'b0;
        case (w_op)
            OP_BRN: begin
                is_branch = 1'b1;
                taken     = 1'b1;
            end
            OP_BRN_Z: begin
                is_branch = 1'b1;
                is_cond   = 1'b1;
                taken     = flag_z;
            end
            OP_BRN_N: begin
                is_branch = 1'b1;
                is_cond   = 1'b1;
                taken     = flag_n;
            end
            OP_BRN_O: begin
                is_branch = 1'b1;
                is_cond   = 1'b1;
                taken     = flag_o;
            end
            default: ;
        endcase
    end

endmodule : branch_resolve
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer
// Purpose  : Owns the program counter, drives the synchronous instruction ROM,
//            resolves branches locally and issues all other words to execute
//            over a valid/ready handshake.
// Ports    : clk, rst_n          - clock, synchronous active-low reset
//            rom_addr, rom_en    - ROM fetch address (combinational) / load
//            rom_data            - word addressed on the previous enabled edge
//            flag_z/n/o          - execute status flags
//            flags_valid         - flags cover every retired instruction
//            instr_out/pc/valid  - issued word, its address, handshake valid
//            instr_ready         - execute accepts the issued word
//            branch_taken        - one-cycle pulse following a redirect
//            halted              - (FETCH_HALT_EN only) self-branch reached
// Config   : FETCH_HALT_EN - an unconditional branch to its own address
//            stops fetching until reset and raises halted.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int N               = 8,
    parameter int ROM_addressBits = 6,
    parameter int RF_addressBits  = 3
) (
    input  logic                            clk,
    input  logic                            rst_n,
    output logic [ROM_addressBits-1:0]      rom_addr,
    output logic                            rom_en,
    input  logic [4+2*RF_addressBits-1:0]   rom_data,
    input  logic                            flag_z,
    input  logic                            flag_n,
    input  logic                            flag_o,
    input  logic                            flags_valid,
    output logic [4+2*RF_addressBits-1:0]   instr_out,
    output logic [ROM_addressBits-1:0]      instr_pc,
    output logic                            instr_valid,
    input  logic                            instr_ready,
    output logic                            branch_taken
`ifdef FETCH_HALT_EN
    ,
    output logic                            halted
`endif
);

    localparam int                   c_W   = 4 + 2*RF_addressBits;
    localparam [ROM_addressBits-1:0] c_ONE = {{(ROM_addressBits-1){1'b0}}, 1'b1};

    // Branch targets are the concatenated register fields, so the address
    // width has to match exactly.
    generate
        if (ROM_addressBits != 2*RF_addressBits || N < 1) begin : g_param_check
            $error("fetch_sequencer: ROM_addressBits must equal 2*RF_addressBits");
        end
    endgenerate

    fetch_state_t               r_state;
    logic [ROM_addressBits-1:0] r_pc;       // address of the word on rom_data
    logic                       r_f_valid;  // rom_data holds a live word

    logic                       w_is_branch;
    logic                       w_is_cond;
    logic                       w_br_taken;
    logic [ROM_addressBits-1:0] w_target;
    logic [ROM_addressBits-1:0] w_pc_inc;
    logic                       w_slot_free;
    logic                       w_flags_ok;
    logic                       w_halt_hit;

    fetch_state_t               w_next_state;
    logic [ROM_addressBits-1:0] w_rom_addr;
    logic                       w_rom_en;
    logic                       w_issue;
    logic                       w_resolve;
    logic                       w_taken;

    branch_resolve #(
        .TARGET_W (ROM_addressBits)
    ) u_branch_resolve (
        .op        (rom_data[c_W-1 -: c_OP_W]),
        .operand   (rom_data[ROM_addressBits-1:0]),
        .flag_z    (flag_z),
        .flag_n    (flag_n),
        .flag_o    (flag_o),
        .is_branch (w_is_branch),
        .is_cond   (w_is_cond),
        .taken     (w_br_taken),
        .target    (w_target)
    );

    assign w_pc_inc    = r_pc + c_ONE;
    assign w_slot_free = !instr_valid || instr_ready;
    // A conditional branch waits until the issue slot has drained so the
    // flags cannot be stale with respect to an instruction still in flight.
    assign w_flags_ok  = flags_valid && !instr_valid;

`ifdef FETCH_HALT_EN
    assign w_halt_hit  = !w_is_cond && (w_target == r_pc);
    assign halted      = (r_state == HALT);
`else
    assign w_halt_hit  = 1'b0;
`endif

    always_comb begin
        w_next_state = r_state;
        w_rom_addr   = w_pc_inc;
        w_rom_en     = 1'b0;
        w_issue      = 1'b0;
        w_resolve    = 1'b0;
        case (r_state)
            IDLE: begin
                w_rom_addr   = '0;
                w_rom_en     = 1'b1;
                w_next_state = RUN;
            end
            RUN: begin
                if (!r_f_valid) begin
                    // Defensive: refetch the current address.
                    w_rom_addr = r_pc;
                    w_rom_en   = 1'b1;
                end else if (!w_is_branch) begin
                    if (w_slot_free) begin
                        w_issue  = 1'b1;
                        w_rom_en = 1'b1;
                    end
                end else if (w_halt_hit) begin
                    w_next_state = HALT;
                end else if (!w_is_cond || w_flags_ok) begin
                    w_resolve = 1'b1;
                end else begin
                    w_next_state = WAIT_FLAGS;
                end
            end
            WAIT_FLAGS: begin
                if (w_flags_ok) begin
                    w_resolve    = 1'b1;
                    w_next_state = RUN;
                end
            end
            HALT: ;
            default: w_next_state = IDLE;
        endcase

        if (w_resolve) begin
            w_rom_en   = 1'b1;
            w_rom_addr = w_br_taken ? w_target : w_pc_inc;
        end
        w_taken = w_resolve && w_br_taken;
    end

    assign rom_addr = w_rom_addr;
    assign rom_en   = w_rom_en;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_pc         <= '0;
            r_f_valid    <= 1'b0;
            instr_out    <= '0;
            instr_pc     <= '0;
            instr_valid  <= 1'b0;
            branch_taken <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            branch_taken <= w_taken;
            if (w_rom_en) begin
                r_pc      <= w_rom_addr;
                r_f_valid <= 1'b1;
            end
            if (w_issue) begin
                instr_out   <= rom_data;
                instr_pc    <= r_pc;
                instr_valid <= 1'b1;
            end else if (instr_ready) begin
                instr_valid <= 1'b0;
            end
        end
    end

endmodule : fetch_sequencer
`default_nettype wire
